// File: rtl/ser_frame_ctrl_pkg.sv
// Shared definitions for the serial DAC frame controller: FSM state encoding,
// default sample width and the fixed per-frame overhead (one idle/capture
// cycle plus one latch cycle).
package ser_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam int DATA_W_DEFAULT = 16;
  localparam int FRAME_OVERHEAD = 2;

endpackage

// File: rtl/ser_frame_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational from the
// requests and the registered last-served pointer; the pointer only moves
// when the parent signals that a grant was actually consumed.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // 1 = channel B was served last, so A wins the next contention
  logic last_b;

  // Grant selection: a lone requester always wins, a tie goes to the other side
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_b ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Last-served pointer, reset so that A wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (update) begin
      last_b <= grant[1];
    end else begin
      last_b <= last_b;
    end
  end

endmodule

// File: rtl/ser_frame_ctrl.sv
// Serial DAC frame controller. Captures one sample from channel A or B
// (round-robin), shifts it out MSB first over DATA_W cycles and finishes
// with a one-cycle latch strobe. Frame length is DATA_W+2 clocks.
// Optional feature macro: SER_PARITY_EN -- drive even parity of the
// captured sample on sdoO during the latch cycle (0 there otherwise).
module ser_frame_ctrl
  import ser_frame_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clkI,
  input  logic              rstnI,
  input  logic              enI,
  input  logic              validAI,
  input  logic              validBI,
  input  logic [DATA_W-1:0] dataAI,
  input  logic [DATA_W-1:0] dataBI,
  output logic              ackAO,
  output logic              ackBO,
  output logic              sdoO,
  output logic              latchO,
  output logic              chanO,
  output logic              busyO
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic [DATA_W-1:0] sel_data;
  logic              sdo_nxt;
  logic              latch_nxt;
  logic              ack_a_nxt;
  logic              ack_b_nxt;
  logic              chan_nxt;
  logic              busy_nxt;
  logic              start;
  logic [1:0]        grant;

`ifdef SER_PARITY_EN
  logic              par;
  logic              par_nxt;

  // Even parity: XOR of all sample bits
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  // A frame starts only from IDLE with the serializer enabled and a request up
  assign start = (state == ST_IDLE) && enI && (validAI || validBI);

  rr_arb2 u_arb (
    .clk    (clkI),
    .rst_n  (rstnI),
    .req    ({validBI, validAI}),
    .update (start),
    .grant  (grant)
  );

  // State, datapath and output registers; reset aborts any frame in flight
  always_ff @(posedge clkI or negedge rstnI) begin
    if (!rstnI) begin
      state  <= ST_IDLE;
      cnt    <= {CNT_W{1'b0}};
      shreg  <= {DATA_W{1'b0}};
      sdoO   <= 1'b0;
      latchO <= 1'b0;
      ackAO  <= 1'b0;
      ackBO  <= 1'b0;
      chanO  <= 1'b0;
      busyO  <= 1'b0;
`ifdef SER_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      shreg  <= shreg_nxt;
      sdoO   <= sdo_nxt;
      latchO <= latch_nxt;
      ackAO  <= ack_a_nxt;
      ackBO  <= ack_b_nxt;
      chanO  <= chan_nxt;
      busyO  <= busy_nxt;
`ifdef SER_PARITY_EN
      par    <= par_nxt;
`endif
    end
  end

  // Next-state logic: IDLE -> SHIFT (DATA_W cycles) -> LATCH (1 cycle) -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt == CNT_LAST) begin
          state_nxt = ST_LATCH;
        end else begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_LATCH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath next values; the MSB is presented in the first SHIFT cycle
  always_comb begin
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    sel_data  = grant[1] ? dataBI : dataAI;
    sdo_nxt   = 1'b0;
    latch_nxt = 1'b0;
    ack_a_nxt = 1'b0;
    ack_b_nxt = 1'b0;
    chan_nxt  = chanO;
    busy_nxt  = (state_nxt != ST_IDLE);
`ifdef SER_PARITY_EN
    par_nxt   = par;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_nxt   = {CNT_W{1'b0}};
          shreg_nxt = {sel_data[DATA_W-2:0], 1'b0};
          sdo_nxt   = sel_data[DATA_W-1];
          ack_a_nxt = grant[0];
          ack_b_nxt = grant[1];
          chan_nxt  = grant[1];
`ifdef SER_PARITY_EN
          par_nxt   = even_parity(sel_data);
`endif
        end else begin
          cnt_nxt   = {CNT_W{1'b0}};
        end
      end
      ST_SHIFT: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = {CNT_W{1'b0}};
          latch_nxt = 1'b1;
`ifdef SER_PARITY_EN
          sdo_nxt   = par;
`else
          sdo_nxt   = 1'b0;
`endif
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
          sdo_nxt   = shreg[DATA_W-1];
          shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
        end
      end
      ST_LATCH: begin
        cnt_nxt = {CNT_W{1'b0}};
      end
      default: begin
        cnt_nxt = {CNT_W{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_ser_frame_ctrl.sv
// Directed self-checking bench for ser_frame_ctrl (DATA_W = 16).
// Honours SER_PARITY_EN for the expected latch-cycle sdo value.
module tb_ser_frame_ctrl;

  logic        clkI = 1'b0;
  logic        rstnI = 1'b0;
  logic        enI = 1'b0;
  logic        validAI = 1'b0;
  logic        validBI = 1'b0;
  logic [15:0] dataAI = 16'h0000;
  logic [15:0] dataBI = 16'h0000;
  logic        ackAO, ackBO, sdoO, latchO, chanO, busyO;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_latch = 0;

`ifdef SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  ser_frame_ctrl #(.DATA_W(16)) dut (
    .clkI    (clkI),
    .rstnI   (rstnI),
    .enI     (enI),
    .validAI (validAI),
    .validBI (validBI),
    .dataAI  (dataAI),
    .dataBI  (dataBI),
    .ackAO   (ackAO),
    .ackBO   (ackBO),
    .sdoO    (sdoO),
    .latchO  (latchO),
    .chanO   (chanO),
    .busyO   (busyO)
  );

  always #10 clkI = ~clkI;

  always @(posedge clkI) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic exp_par(input logic [15:0] d);
    return PAR_EN & (^d);
  endfunction

  // Wait (bounded) for the first SHIFT cycle; returns at its falling edge
  task automatic wait_busy(input string tag, input int max);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clkI);
      if (busyO === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_start"}, 32'(ok), 32'd1);
  endtask

  // Called at the falling edge of the first SHIFT cycle; walks the whole frame
  task automatic check_frame(input string tag, input logic [15:0] d, input logic ch,
                             input int drop_en_at);
    logic [15:0] bits;
    logic        stray_latch;
    bits = 16'h0000;
    stray_latch = 1'b0;
    chk({tag, "_ack"}, 32'({ackAO, ackBO}), 32'({~ch, ch}));
    chk({tag, "_chan"}, 32'(chanO), 32'(ch));
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clkI);
      if (i == drop_en_at) enI = 1'b0;
      if (i == 1) chk({tag, "_ack_one_cycle"}, 32'({ackAO, ackBO}), 32'd0);
      bits = {bits[14:0], sdoO};
      stray_latch = stray_latch | latchO | ~busyO;
    end
    chk({tag, "_serial"}, 32'(bits), 32'(d));
    chk({tag, "_shift_ctl"}, 32'(stray_latch), 32'd0);
    @(negedge clkI);
    chk({tag, "_latch"}, 32'({latchO, busyO, sdoO}), 32'({2'b11, exp_par(d)}));
    last_latch = cyc;
    @(negedge clkI);
    chk({tag, "_idle"}, 32'({latchO, busyO, sdoO}), 32'd0);
  endtask

  initial begin
    int prev;
    logic stray;

    // Reset state
    repeat (3) @(negedge clkI);
    chk("reset_outs", 32'({sdoO, latchO, ackAO, ackBO, busyO, chanO}), 32'd0);
    rstnI = 1'b1;
    @(negedge clkI);

    // Single A frame, A5C3
    enI = 1'b1; validAI = 1'b1; dataAI = 16'hA5C3;
    wait_busy("a5c3", 4);
    validAI = 1'b0; dataAI = 16'h0000;
    check_frame("a5c3", 16'hA5C3, 1'b0, -1);

    // Fresh reset, then both channels held: A,B,A,B every 18 cycles
    rstnI = 1'b0;
    @(negedge clkI);
    rstnI = 1'b1;
    dataAI = 16'h0001; dataBI = 16'h8000;
    validAI = 1'b1; validBI = 1'b1;
    wait_busy("rr0", 4);
    check_frame("rr0", 16'h0001, 1'b0, -1);
    prev = last_latch;
    for (int k = 1; k < 4; k++) begin
      wait_busy($sformatf("rr%0d", k), 4);
      check_frame($sformatf("rr%0d", k), (k % 2 == 1) ? 16'h8000 : 16'h0001, k % 2 == 1, -1);
      chk($sformatf("rr%0d_period", k), 32'(last_latch - prev), 32'd18);
      prev = last_latch;
    end
    validAI = 1'b0; validBI = 1'b0;

    // enI dropped at SHIFT cycle 5: frame completes, then stays idle
    @(negedge clkI);
    validAI = 1'b1; dataAI = 16'h1234;
    wait_busy("endrop", 4);
    check_frame("endrop", 16'h1234, 1'b0, 5);
    stray = 1'b0;
    repeat (4) begin
      @(negedge clkI);
      stray = stray | busyO | sdoO | ackAO | ackBO;
    end
    chk("endrop_stays_idle", 32'(stray), 32'd0);
    validAI = 1'b0;

    // Reset asserted at SHIFT bit 8 of a B frame
    enI = 1'b1; validBI = 1'b1; dataBI = 16'hF0F0;
    wait_busy("rst_mid", 4);
    chk("rst_mid_chan_b", 32'(chanO), 32'd1);
    repeat (8) @(negedge clkI);
    #5 rstnI = 1'b0;
    #1 chk("rst_mid_async", 32'({sdoO, latchO, ackAO, ackBO, busyO, chanO}), 32'd0);
    @(negedge clkI);
    chk("rst_mid_no_latch", 32'({latchO, busyO}), 32'd0);
    validAI = 1'b1; dataAI = 16'h00FF;
    rstnI = 1'b1;
    wait_busy("rst_after", 4);
    validAI = 1'b0; validBI = 1'b0;
    check_frame("rst_after", 16'h00FF, 1'b0, -1);

    // B-only frame with 0003 (parity 0), leaves pointer at "B served"
    validBI = 1'b1; dataBI = 16'h0003;
    wait_busy("par3", 4);
    validBI = 1'b0;
    check_frame("par3", 16'h0003, 1'b1, -1);

    // validB pulsed one cycle with enI low: no grant, no frame
    enI = 1'b0;
    validBI = 1'b1;
    @(negedge clkI);
    validBI = 1'b0;
    stray = 1'b0;
    repeat (5) begin
      @(negedge clkI);
      stray = stray | busyO | ackAO | ackBO;
    end
    chk("pulse_no_grant", 32'(stray), 32'd0);

    // Next contention must go to A; data 0007 (parity 1)
    enI = 1'b1; validAI = 1'b1; validBI = 1'b1; dataAI = 16'h0007; dataBI = 16'hFFFF;
    wait_busy("par7", 4);
    validAI = 1'b0; validBI = 1'b0;
    check_frame("par7", 16'h0007, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
